// File: rtl/humanlike_rtc.sv
`default_nettype none
// ============================================================================
//  Module   : humanlike_rtc
//  Purpose  : Millisecond-resolution real-time clock. A prescaler divides the
//             input clock down to 1 kHz and drives a packed
//             hours:minutes:seconds.milliseconds counter, with a one-cycle
//             load interface (validated) and a single-shot alarm compare.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLK_FREQ_HZ  input clock frequency, integer multiple of 1000, >= 2000
//    HOUR_W       width of the hours field
//    HOURS_WRAP   hour modulus, 2 .. 2**HOUR_W
//  Ports (time values are packed {hours[HOUR_W], min[6], sec[6], ms[10]})
//    clock       in   single clock, rising edge
//    reset       in   asynchronous, active-low reset
//    enable      in   1 = run, 0 = hold prescaler and time
//    load        in   one-cycle request to load set_time
//    set_time    in   value to load
//    alarm_en    in   alarm compare enable
//    alarm_time  in   alarm value
//    rtc_time    out  current time (registered)
//    ms_tick     out  one-cycle pulse with every millisecond advance
//    sec_tick    out  one-cycle pulse with every seconds-field advance
//    alarm       out  one-cycle pulse when counting reaches alarm_time
//    load_err    out  one-cycle pulse when a load is rejected
// ============================================================================
module humanlike_rtc #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int HOUR_W      = 5,
    parameter int HOURS_WRAP  = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load,
    input  logic [HOUR_W+21:0]   set_time,
    input  logic                 alarm_en,
    input  logic [HOUR_W+21:0]   alarm_time,
    // "time" is a reserved word in SystemVerilog, so the current-time
    // output carries the rtc_ prefix.
    output logic [HOUR_W+21:0]   rtc_time,
    output logic                 ms_tick,
    output logic                 sec_tick,
    output logic                 alarm,
    output logic                 load_err
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int               C_DIV       = CLK_FREQ_HZ / 1000;
    localparam int               C_PW        = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam logic [C_PW-1:0]  C_PRESC_MAX = C_PW'(C_DIV - 1);
    localparam logic [HOUR_W-1:0] C_HOUR_MAX = HOUR_W'(HOURS_WRAP - 1);
    // One bit wider than the hours field so HOURS_WRAP == 2**HOUR_W fits.
    localparam logic [HOUR_W:0]  C_HOUR_LIM  = (HOUR_W + 1)'(HOURS_WRAP);
    localparam logic [9:0]       C_MS_MAX    = 10'd999;
    localparam logic [5:0]       C_SIXTY_MAX = 6'd59;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [C_PW-1:0]   r_presc;
    logic [HOUR_W-1:0] r_hour;
    logic [5:0]        r_min;
    logic [5:0]        r_sec;
    logic [9:0]        r_ms;
    logic              r_ms_tick;
    logic              r_sec_tick;
    logic              r_alarm;
    logic              r_load_err;

    // ------------------------------------------------------------------
    // Load request decode and validation
    // ------------------------------------------------------------------
    logic [HOUR_W-1:0] w_set_hour;
    logic [5:0]        w_set_min;
    logic [5:0]        w_set_sec;
    logic [9:0]        w_set_ms;
    logic              w_set_valid;
    logic              w_load_ok;
    logic              w_load_bad;

    assign w_set_hour  = set_time[HOUR_W+21:22];
    assign w_set_min   = set_time[21:16];
    assign w_set_sec   = set_time[15:10];
    assign w_set_ms    = set_time[9:0];

    assign w_set_valid = (w_set_ms  <= C_MS_MAX)    &&
                         (w_set_sec <= C_SIXTY_MAX) &&
                         (w_set_min <= C_SIXTY_MAX) &&
                         ({1'b0, w_set_hour} < C_HOUR_LIM);

    assign w_load_ok   = load &&  w_set_valid;
    assign w_load_bad  = load && !w_set_valid;

    // ------------------------------------------------------------------
    // Counting: the ms advance fires on the prescaler's terminal count.
    // The carry chain below is purely combinational so that a full
    // rollover (max:59:59.999 -> 0:00:00.000) lands on a single edge.
    // ------------------------------------------------------------------
    logic              w_adv;
    logic              w_ms_wrap;
    logic              w_sec_wrap;
    logic              w_min_wrap;
    logic              w_hour_wrap;
    logic [9:0]        w_ms_nx;
    logic [5:0]        w_sec_nx;
    logic [5:0]        w_min_nx;
    logic [HOUR_W-1:0] w_hour_nx;
    logic [HOUR_W+21:0] w_time_nx;

    assign w_adv       = enable && (r_presc == C_PRESC_MAX);
    assign w_ms_wrap   = (r_ms   == C_MS_MAX);
    assign w_sec_wrap  = (r_sec  == C_SIXTY_MAX);
    assign w_min_wrap  = (r_min  == C_SIXTY_MAX);
    assign w_hour_wrap = (r_hour == C_HOUR_MAX);

    always_comb begin
        w_ms_nx   = r_ms;
        w_sec_nx  = r_sec;
        w_min_nx  = r_min;
        w_hour_nx = r_hour;

        if (w_ms_wrap) begin
            w_ms_nx = '0;
            if (w_sec_wrap) begin
                w_sec_nx = '0;
                if (w_min_wrap) begin
                    w_min_nx  = '0;
                    w_hour_nx = w_hour_wrap ? '0 : r_hour + 1'b1;
                end else begin
                    w_min_nx = r_min + 1'b1;
                end
            end else begin
                w_sec_nx = r_sec + 1'b1;
            end
        end else begin
            w_ms_nx = r_ms + 1'b1;
        end
    end

    assign w_time_nx = {w_hour_nx, w_min_nx, w_sec_nx, w_ms_nx};

    // ------------------------------------------------------------------
    // Sequential update. Pulses default low every cycle; a valid load
    // overrides (and discards) any coincident advance and never produces
    // a tick or alarm, so an alarm can only come from counting.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc    <= '0;
            r_hour     <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_ms       <= '0;
            r_ms_tick  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_alarm    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_ms_tick  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_alarm    <= 1'b0;
            r_load_err <= w_load_bad;

            if (w_load_ok) begin
                r_presc <= '0;
                r_hour  <= w_set_hour;
                r_min   <= w_set_min;
                r_sec   <= w_set_sec;
                r_ms    <= w_set_ms;
            end else if (enable) begin
                if (w_adv) begin
                    r_presc    <= '0;
                    r_hour     <= w_hour_nx;
                    r_min      <= w_min_nx;
                    r_sec      <= w_sec_nx;
                    r_ms       <= w_ms_nx;
                    r_ms_tick  <= 1'b1;
                    // Seconds field changes exactly when ms rolls over.
                    r_sec_tick <= w_ms_wrap;
                    r_alarm    <= alarm_en && (w_time_nx == alarm_time);
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers.
    // ------------------------------------------------------------------
    assign rtc_time = {r_hour, r_min, r_sec, r_ms};
    assign ms_tick  = r_ms_tick;
    assign sec_tick = r_sec_tick;
    assign alarm    = r_alarm;
    assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_humanlike_rtc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_humanlike_rtc
//  Purpose  : Self-checking bench for humanlike_rtc (DIV = 4). Two instances:
//             HOURS_WRAP = 24 (main) and HOURS_WRAP = 12 (wrap check),
//             sharing all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_humanlike_rtc;

    localparam int TW = 27;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          load;
    logic [TW-1:0] set_time;
    logic          alarm_en;
    logic [TW-1:0] alarm_time;

    logic [TW-1:0] t24, t12;
    logic          ms24, ss24, al24, er24;
    logic          ms12, ss12, al12, er12;

    int n_tests = 0;
    int n_fail  = 0;

    humanlike_rtc #(.CLK_FREQ_HZ(4000), .HOUR_W(5), .HOURS_WRAP(24)) dut24 (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .set_time(set_time), .alarm_en(alarm_en), .alarm_time(alarm_time),
        .rtc_time(t24), .ms_tick(ms24), .sec_tick(ss24), .alarm(al24),
        .load_err(er24)
    );

    humanlike_rtc #(.CLK_FREQ_HZ(4000), .HOUR_W(5), .HOURS_WRAP(12)) dut12 (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .set_time(set_time), .alarm_en(alarm_en), .alarm_time(alarm_time),
        .rtc_time(t12), .ms_tick(ms12), .sec_tick(ss12), .alarm(al12),
        .load_err(er12)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          en;
        logic          ld;
        logic [TW-1:0] st;
        logic          aen;
        logic [TW-1:0] at;
        int            n;
        logic [TW-1:0] et;
        logic          ems;
        logic          ess;
        logic          eal;
        logic          eerr;
    } vec_t;

    vec_t vt[26];
    vec_t exp_q[$];

    function automatic logic [TW-1:0] pk(int h, int m, int s, int ms);
        return {5'(h), 6'(m), 6'(s), 10'(ms)};
    endfunction

    function automatic vec_t mk(logic en, logic ld, logic [TW-1:0] st,
                                logic aen, logic [TW-1:0] at, int n,
                                logic [TW-1:0] et, logic ems, logic ess,
                                logic eal, logic eerr);
        vec_t v;
        v.en = en; v.ld = ld; v.st = st; v.aen = aen; v.at = at; v.n = n;
        v.et = et; v.ems = ems; v.ess = ess; v.eal = eal; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk_t(input string nm, input logic [TW-1:0] act,
                         input logic [TW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d:%0d.%0d, expected %0d:%0d:%0d.%0d",
                     nm, act[26:22], act[21:16], act[15:10], act[9:0],
                     exp[26:22], exp[21:16], exp[15:10], exp[9:0]);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Advance n rising edges, then sit 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        enable     = v.en;
        alarm_en   = v.aen;
        alarm_time = v.at;
        if (v.ld) begin
            load     = 1'b1;
            set_time = v.st;
        end
        exp_q.push_back(v);
        tick(1);
        load = 1'b0;
        if (v.n > 1) tick(v.n - 1);
        e = exp_q.pop_front();
        chk_t($sformatf("v%0d.time", idx),     t24,  e.et);
        chk_b($sformatf("v%0d.ms_tick", idx),  ms24, e.ems);
        chk_b($sformatf("v%0d.sec_tick", idx), ss24, e.ess);
        chk_b($sformatf("v%0d.alarm", idx),    al24, e.eal);
        chk_b($sformatf("v%0d.load_err", idx), er24, e.eerr);
    endtask

    initial begin
        // -------------------------- vector table --------------------------
        vt[0]  = mk(1'b1, 1'b1, pk(23,59,59,999), 1'b0, 27'd0, 1,    pk(23,59,59,999), 1'b0, 1'b0, 1'b0, 1'b0);
        vt[1]  = mk(1'b1, 1'b0, 27'd0,            1'b0, 27'd0, 3,    pk(23,59,59,999), 1'b0, 1'b0, 1'b0, 1'b0);
        vt[2]  = mk(1'b1, 1'b0, 27'd0,            1'b0, 27'd0, 1,    pk(0,0,0,0),      1'b1, 1'b1, 1'b0, 1'b0);
        vt[3]  = mk(1'b1, 1'b1, pk(1,2,60,5),     1'b0, 27'd0, 1,    pk(0,0,0,0),      1'b0, 1'b0, 1'b0, 1'b1);
        vt[4]  = mk(1'b1, 1'b0, 27'd0,            1'b0, 27'd0, 1,    pk(0,0,0,0),      1'b0, 1'b0, 1'b0, 1'b0);
        vt[5]  = mk(1'b1, 1'b1, pk(24,0,0,0),     1'b0, 27'd0, 1,    pk(0,0,0,0),      1'b0, 1'b0, 1'b0, 1'b1);
        vt[6]  = mk(1'b1, 1'b0, 27'd0,            1'b0, 27'd0, 1,    pk(0,0,0,1),      1'b1, 1'b0, 1'b0, 1'b0);
        vt[7]  = mk(1'b1, 1'b1, pk(5,6,7,8),      1'b0, 27'd0, 1,    pk(5,6,7,8),      1'b0, 1'b0, 1'b0, 1'b0);
        vt[8]  = mk(1'b1, 1'b1, pk(0,0,0,1000),   1'b0, 27'd0, 1,    pk(5,6,7,8),      1'b0, 1'b0, 1'b0, 1'b1);
        vt[9]  = mk(1'b1, 1'b0, 27'd0,            1'b0, 27'd0, 3,    pk(5,6,7,9),      1'b1, 1'b0, 1'b0, 1'b0);
        vt[10] = mk(1'b1, 1'b0, 27'd0,            1'b0, 27'd0, 3,    pk(5,6,7,9),      1'b0, 1'b0, 1'b0, 1'b0);
        vt[11] = mk(1'b1, 1'b1, pk(2,3,4,5),      1'b0, 27'd0, 1,    pk(2,3,4,5),      1'b0, 1'b0, 1'b0, 1'b0);
        vt[12] = mk(1'b1, 1'b0, 27'd0,            1'b0, 27'd0, 4,    pk(2,3,4,6),      1'b1, 1'b0, 1'b0, 1'b0);
        vt[13] = mk(1'b0, 1'b1, pk(0,0,0,999),    1'b0, 27'd0, 1,    pk(0,0,0,999),    1'b0, 1'b0, 1'b0, 1'b0);
        vt[14] = mk(1'b0, 1'b0, 27'd0,            1'b0, 27'd0, 10,   pk(0,0,0,999),    1'b0, 1'b0, 1'b0, 1'b0);
        vt[15] = mk(1'b1, 1'b0, 27'd0,            1'b0, 27'd0, 4,    pk(0,0,1,0),      1'b1, 1'b1, 1'b0, 1'b0);
        vt[16] = mk(1'b1, 1'b1, pk(0,0,0,0),      1'b1, pk(0,0,1,0), 1,    pk(0,0,0,0),   1'b0, 1'b0, 1'b0, 1'b0);
        vt[17] = mk(1'b1, 1'b0, 27'd0,            1'b1, pk(0,0,1,0), 3999, pk(0,0,0,999), 1'b0, 1'b0, 1'b0, 1'b0);
        vt[18] = mk(1'b1, 1'b0, 27'd0,            1'b1, pk(0,0,1,0), 1,    pk(0,0,1,0),   1'b1, 1'b1, 1'b1, 1'b0);
        vt[19] = mk(1'b1, 1'b0, 27'd0,            1'b1, pk(0,0,1,0), 1,    pk(0,0,1,0),   1'b0, 1'b0, 1'b0, 1'b0);
        vt[20] = mk(1'b1, 1'b1, pk(0,0,0,999),    1'b0, pk(0,0,1,0), 1,    pk(0,0,0,999), 1'b0, 1'b0, 1'b0, 1'b0);
        vt[21] = mk(1'b1, 1'b0, 27'd0,            1'b0, pk(0,0,1,0), 4,    pk(0,0,1,0),   1'b1, 1'b1, 1'b0, 1'b0);
        vt[22] = mk(1'b1, 1'b1, pk(0,0,1,0),      1'b1, pk(0,0,2,0), 1,    pk(0,0,1,0),   1'b0, 1'b0, 1'b0, 1'b0);
        vt[23] = mk(1'b1, 1'b0, 27'd0,            1'b1, pk(0,0,1,0), 3,    pk(0,0,1,0),   1'b0, 1'b0, 1'b0, 1'b0);
        vt[24] = mk(1'b1, 1'b0, 27'd0,            1'b1, pk(0,0,1,1), 1,    pk(0,0,1,1),   1'b1, 1'b0, 1'b1, 1'b0);
        vt[25] = mk(1'b1, 1'b0, 27'd0,            1'b1, pk(0,0,1,1), 1,    pk(0,0,1,1),   1'b0, 1'b0, 1'b0, 1'b0);

        // ------------------------------ reset -----------------------------
        reset      = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        set_time   = '0;
        alarm_en   = 1'b0;
        alarm_time = '0;
        tick(2);
        chk_t("rst.time",     t24,  '0);
        chk_b("rst.ms_tick",  ms24, 1'b0);
        chk_b("rst.sec_tick", ss24, 1'b0);
        chk_b("rst.alarm",    al24, 1'b0);
        chk_b("rst.load_err", er24, 1'b0);

        // ------------- release with enable: first advance on edge 4 -------
        reset  = 1'b1;
        enable = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            chk_t($sformatf("boot%0d.time", e),    t24,  pk(0,0,0,e/4));
            chk_b($sformatf("boot%0d.ms_tick", e), ms24, (e % 4 == 0));
        end

        // --------------------------- table run ----------------------------
        for (int i = 0; i < 26; i++) apply(i, vt[i]);

        // ------------- pause mid-prescale, resume from held count ---------
        alarm_en = 1'b0;
        enable   = 1'b1;
        load     = 1'b1;
        set_time = pk(0,0,0,0);
        tick(1);
        load = 1'b0;
        tick(2);
        chk_t("pause.pre.time", t24, pk(0,0,0,0));
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk_t($sformatf("pause%0d.time", c),     t24,  pk(0,0,0,0));
            chk_b($sformatf("pause%0d.ms_tick", c),  ms24, 1'b0);
            chk_b($sformatf("pause%0d.sec_tick", c), ss24, 1'b0);
        end
        enable = 1'b1;
        tick(1);
        chk_t("resume1.time",    t24,  pk(0,0,0,0));
        chk_b("resume1.ms_tick", ms24, 1'b0);
        tick(1);
        chk_t("resume2.time",    t24,  pk(0,0,0,1));
        chk_b("resume2.ms_tick", ms24, 1'b1);

        // --------- asynchronous reset between edges while ms_tick high ----
        #2;
        reset = 1'b0;
        #1;
        chk_t("areset.time",    t24,  '0);
        chk_b("areset.ms_tick", ms24, 1'b0);
        chk_b("areset.ms12",    ms12, 1'b0);
        #3;
        reset = 1'b1;
        tick(3);
        chk_t("rel3.time",    t24,  '0);
        chk_b("rel3.ms_tick", ms24, 1'b0);
        tick(1);
        chk_t("rel4.time",    t24,  pk(0,0,0,1));
        chk_b("rel4.ms_tick", ms24, 1'b1);

        // ------------------- 12-hour instance rollover --------------------
        load     = 1'b1;
        set_time = pk(11,59,59,999);
        tick(1);
        load = 1'b0;
        chk_t("h12.load.time", t12, pk(11,59,59,999));
        tick(4);
        chk_t("h12.wrap.time",     t12,  pk(0,0,0,0));
        chk_b("h12.wrap.ms_tick",  ms12, 1'b1);
        chk_b("h12.wrap.sec_tick", ss12, 1'b1);
        chk_t("h24.noon.time",     t24,  pk(12,0,0,0));
        load     = 1'b1;
        set_time = pk(12,0,0,0);
        tick(1);
        load = 1'b0;
        chk_b("h12.badhour.load_err", er12, 1'b1);
        chk_t("h12.badhour.time",     t12,  pk(0,0,0,0));
        chk_b("h24.hour12.load_err",  er24, 1'b0);
        chk_t("h24.hour12.time",      t24,  pk(12,0,0,0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
